// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a program counter, a 2-entry
// {instr, pc, fault} buffer, redirect/flush and fetch-fault detection.
//
// Handshake (decode side): instr_valid_o is high whenever the buffer holds an
// entry, and it never depends on instr_ready_i. An entry transfers on a rising
// edge where instr_valid_o && instr_ready_i. While instr_valid_o is high, the
// head fields (instr_o, instr_pc_o, fault_o) stay stable until they transfer
// or a redirect flushes them. While instr_valid_o is low, the head fields are
// driven to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_LIMIT = 32'd4095
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fault_o,
    output logic        dbg_halt_o
);

    // RUN fetches every cycle the buffer has room. HALT stops fetching after
    // a fault has been captured, and only a redirect leaves it.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } mode_e;

    mode_e       mode_q;
    mode_e       mode_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic        buf_fault [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;

    logic        deq;
    logic        enq;
    logic        fetch_fault;

    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (count_q != 2'd0);
    assign deq           = instr_valid_o && instr_ready_i;

    // A full buffer can still accept a new entry in the cycle its head leaves.
    assign enq = (mode_q == RUN) && !redirect_i && ((count_q != 2'd2) || deq);

    // Misaligned PCs and PCs past the end of instruction memory cannot be
    // fetched. Redirect targets are not corrected, so they are caught here.
    assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q > IMEM_LIMIT);

    // Head fields are zero when the buffer is empty.
    assign instr_o    = instr_valid_o ? buf_instr[rd_ptr_q] : 32'h0;
    assign instr_pc_o = instr_valid_o ? buf_pc[rd_ptr_q]    : 32'h0;
    assign fault_o    = instr_valid_o ? buf_fault[rd_ptr_q] : 1'b0;

    assign dbg_halt_o = (mode_q == HALT);

    // Next mode: a redirect always resumes fetching, and a captured fault halts.
    always_comb begin
        mode_d = mode_q;
        if (redirect_i) begin
            mode_d = RUN;
        end else if (enq && fetch_fault) begin
            mode_d = HALT;
        end
    end

    // Next PC: load the redirect target, or step past a successfully fetched
    // word. A faulting PC is held so imem_addr_o shows where fetch stopped.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (enq && !fetch_fault) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Mode and PC registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= RUN;
            pc_q   <= RESET_PC;
        end else begin
            mode_q <= mode_d;
            pc_q   <= pc_d;
        end
    end

    // Buffer bookkeeping. A redirect discards everything, including an entry
    // dequeued in the same cycle, which decode has already taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (redirect_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (enq) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage. The memory is combinational, so the word for pc_q is
    // captured on the same edge that the PC advances. Fault entries carry no
    // instruction word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= 32'h0;
                buf_pc[i]    <= 32'h0;
                buf_fault[i] <= 1'b0;
            end
        end else if (enq) begin
            buf_instr[wr_ptr_q] <= fetch_fault ? 32'h0 : imem_data_i;
            buf_pc[wr_ptr_q]    <= pc_q;
            buf_fault[wr_ptr_q] <= fetch_fault;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus for fetch_unit. A queue-based
// reference model predicts buffered entries, and a negedge monitor checks them.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] IMEM_LIMIT = 32'd4095;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fault_o;
    logic        dbg_halt_o;

    // Instruction memory: random words, read combinationally.
    logic [31:0] mem [1024];
    assign imem_data_i = mem[imem_addr_o[11:2]];

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .IMEM_LIMIT(IMEM_LIMIT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .fault_o      (fault_o),
        .dbg_halt_o   (dbg_halt_o)
    );

    // ---------------- reference model + scoreboard ----------------
    // exp_q holds the entries the buffer should contain, as {instr, pc, fault}.
    logic [64:0] exp_q[$];
    logic [31:0] mpc = RESET_PC;
    logic        halted = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the fetch rules for the coming rising edge. A dequeue has
    // already been removed from exp_q by the monitor at this point.
    task automatic model_step();
        if (!rst_ni) return;
        if (redirect_i) begin
            exp_q.delete();
            mpc    = redirect_pc_i;
            halted = 1'b0;
        end else if (!halted && exp_q.size() < 2) begin
            if (mpc[1:0] != 2'b00 || mpc > IMEM_LIMIT) begin
                exp_q.push_back({32'h0, mpc, 1'b1});
                halted = 1'b1;
            end else begin
                exp_q.push_back({mem[mpc[11:2]], mpc, 1'b0});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // Monitor: compare what the DUT presents with the model, pop on handshake.
    always @(negedge clk) begin
        check("valid", {64'h0, instr_valid_o}, {64'h0, exp_q.size() != 0});
        check("imem_addr", {33'h0, imem_addr_o}, {33'h0, mpc});
        check("halt_mode", {64'h0, dbg_halt_o}, {64'h0, halted});
        if (exp_q.size() != 0) begin
            check("head", {instr_o, instr_pc_o, fault_o}, exp_q[0]);
            if (instr_ready_i && rst_ni) begin
                void'(exp_q.pop_front());
                delivered++;
            end
        end else begin
            check("idle_zero", {instr_o, instr_pc_o, fault_o}, 65'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        @(negedge clk);
        #1;
        model_step();
    endtask

    task automatic do_release(input logic rdy);
        @(posedge clk);
        #1;
        rst_ni        = 1'b1;
        instr_ready_i = rdy;
        redirect_i    = 1'b0;
        @(negedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni     = 1'b0;
        redirect_i = 1'b0;
        #1;
        check("rst_valid", {64'h0, instr_valid_o}, 65'h0);
        check("rst_addr", {33'h0, imem_addr_o}, {33'h0, RESET_PC});
        check("rst_head", {instr_o, instr_pc_o, fault_o}, 65'h0);
        exp_q.delete();
        mpc    = RESET_PC;
        halted = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            1:       t = 32'd4080 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            2:       t = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            default: t = 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        // Reset release with decode always ready: A, B, C, D, ... in order.
        repeat (2) @(posedge clk);
        do_release(1'b1);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Backpressure from reset: buffer fills with A, B and the PC holds at 8.
        do_reset();
        do_release(1'b0);
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        check("bp_addr_hold", {33'h0, imem_addr_o}, 65'd8);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Redirect to 0x40 while full: old entries are flushed.
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h40);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Run into the end of memory: 4092 normal, 4096 faults, fetch stops.
        cycle(1'b1, 1'b1, 32'd4084);
        repeat (8) cycle(1'b1, 1'b0, 32'h0);
        check("halt_addr", {33'h0, imem_addr_o}, 65'd4096);
        check("halt_flag", {64'h0, dbg_halt_o}, 65'd1);

        // In HALT: misaligned redirect faults, aligned redirect resumes.
        cycle(1'b1, 1'b1, 32'h2);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h8);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Reset mid-stream with two buffered entries, then restart.
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        do_reset();
        do_release(1'b1);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic rdy;
            logic redir;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 11) == 0);
            cycle(rdy, redir, redir ? rand_target() : 32'h0);
        end

        // Drain and confirm that entries flowed at all.
        repeat (4) cycle(1'b1, 1'b0, 32'h0);
        check("delivered_some", {64'h0, delivered > 50}, 65'd1);

        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage in front of the core's combinational instruction memory. Holds the program counter, presents it as the word address, captures the returned instruction word with its PC into a 2-entry buffer, and hands entries to decode over a valid/ready handshake. Supports redirect from branches/jumps with buffer flush, and flags misaligned or out-of-range fetches as faults.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded at reset; must be word-aligned.
- IMEM_LIMIT, 32'd4095: highest valid byte address of instruction memory; a PC above it faults.
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- imem_addr_o  output  32  byte address to instruction memory; equals the PC register.
- imem_data_i  input  32  instruction word returned combinationally for imem_addr_o.
- redirect_i  input  1  taken branch/jump; flush and reload the PC.
- redirect_pc_i  input  32  new PC, sampled when redirect_i=1.
- instr_valid_o  output  1  buffer head is valid.
- instr_ready_i  input  1  decode accepts the head this cycle.
- instr_o  output  32  head instruction word.
- instr_pc_o  output  32  PC of the head instruction.
- fault_o  output  1  head entry is a fetch fault.

## Operation
- State: PC register, 2-entry FIFO of {instr, pc, fault}, wr/rd pointers, count 0..2, mode RUN/HALT.
- Reset values: PC=RESET_PC, count=0, mode=RUN, instr_valid_o=0, instr_o=0, instr_pc_o=0, fault_o=0, imem_addr_o=RESET_PC.
- When count=0, instr_o, instr_pc_o and fault_o are driven 0.
- Dequeue: instr_valid_o && instr_ready_i.
- Enqueue: mode=RUN && !redirect_i && (count<2 || dequeue). Simultaneous enqueue and dequeue at count=2 is allowed; count stays 2.
- Fault check on enqueue: fault if PC[1:0]!=0 or PC>IMEM_LIMIT.
- Normal enqueue writes {imem_data_i, PC, 0}, then PC <= PC+4 (32-bit, wraps modulo 2^32).
- Fault enqueue writes {32'h0, PC, 1}, leaves PC unchanged, and sets mode=HALT. No further enqueues occur in HALT.
- Redirect has highest priority:
  - count<=0, pointers reset, PC<=redirect_pc_i, mode<=RUN.
  - No enqueue in that cycle. A same-cycle dequeue is treated as consumed but has no further effect.
  - Redirect in HALT is the only exit from HALT.
- A misaligned redirect_pc_i is not corrected; it produces a fault entry on the next enqueue.
- Mode transitions: RUN -> HALT on fault enqueue; HALT -> RUN on redirect_i; otherwise hold.

## Timing
- Memory read is combinational, so an enqueue captures imem_data_i in the same cycle the PC is presented.
- Fetch latency: the first instruction is valid after the first rising edge following reset release.
- Redirect latency: redirect_i high at edge N makes instr_valid_o low after N; the target instruction is valid after edge N+1.
- Throughput: one instruction per cycle while instr_ready_i=1.
- Backpressure: with instr_ready_i=0 the buffer fills in 2 cycles, then the PC holds and imem_addr_o is stable.
- Outputs change only on clock edges, or asynchronously on reset assertion.
- Reset mid-operation immediately forces all reset values, discarding buffered entries.

## Test plan
- Reset release, RESET_PC=0, memory words 0..3 = A,B,C,D, instr_ready_i=1 -> instr_o/instr_pc_o = A/0, B/4, C/8, D/12 on consecutive cycles; fault_o=0.
- instr_ready_i=0 for 5 cycles after reset -> count reaches 2, imem_addr_o holds at 8. Then ready=1 -> A, B, C delivered in order with no loss or duplication.
- Redirect to 0x40 while buffer is full -> instr_valid_o=0 for one cycle, next entry is pc=0x40 with word[16]; older entries are never delivered.
- PC reaches 4092 then 4096 (IMEM_LIMIT=4095) -> entry pc=4092 normal; entry pc=4096 has fault_o=1, instr_o=0; no further entries; imem_addr_o stays 4096.
- In HALT, redirect to 0x2 -> fault entry pc=0x2. Then redirect to 0x8 -> normal fetch resumes at 0x8.
- rst_ni pulsed low mid-stream with 2 entries buffered -> instr_valid_o=0 immediately, PC=RESET_PC; after release, fetch restarts from RESET_PC.
